sent_tx_frame_sched: RTL

Frame scheduler between the TX async FIFO read port and the SENT frame generator. Pops one 12-bit fast-channel word per frame, offers it with a status nibble through a req/ack handshake, and sequences the 16-frame short serial message on status bits 3:2. Holds the last word and flags underrun when the FIFO is empty. Runs on a single clock on the read side of the TX FIFO.

---
 rtl/sent_tx_frame_sched.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sent_tx_frame_sched.sv
// sent_tx_frame_sched
//   Frame scheduler between the TX async FIFO read port and the SENT frame
//   generator. Pops one fast-channel word per frame, offers it with a status
//   nibble over a req/ack handshake and sequences the 16-frame short serial
//   message on status bits 3:2. When the FIFO is empty at a decision point,
//   the last word is re-offered and the sticky underrun flag is set.
//
// Ports
//   PCLK, PRESETn        clock, synchronous active-low reset
//   enable               scheduling enable (level)
//   ser_id, ser_data     serial message content, latched at message start
//   fifo_empty           TX FIFO empty
//   fifo_rdata           TX FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en           one-cycle pop strobe
//   frame_req/frame_ack  frame handshake; transfer = frame_req & frame_ack
//   frame_status         {start, serial bit, 2'b00}
//   frame_data           fast-channel word for the offered frame
//   underrun             sticky empty-FIFO flag, cleared by underrun_clr
//   msg_done             one-cycle pulse after the 16th serial frame
//   busy                 state != IDLE
module sent_tx_frame_sched #(
  parameter int unsigned DATAWIDTH = 12
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 enable,
  input  logic [3:0]           ser_id,
  input  logic [7:0]           ser_data,
  input  logic                 fifo_empty,
  input  logic [DATAWIDTH-1:0] fifo_rdata,
  output logic                 fifo_rd_en,
  output logic                 frame_req,
  input  logic                 frame_ack,
  output logic [3:0]           frame_status,
  output logic [DATAWIDTH-1:0] frame_data,
  output logic                 underrun,
  input  logic                 underrun_clr,
  output logic                 msg_done,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, OFFER} state_t;

  state_t      state, state_nxt;
  logic [3:0]  ser_idx, ser_idx_nxt;
  logic [15:0] msg;
  logic [3:0]  crc;
  logic        transfer, decision, enter_offer;

  // Multiply the running remainder by x^4 modulo x^4+x^3+x^2+1, then add
  // the next nibble.
  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic [3:0] nib);
    logic [3:0] r;
    r = c;
    for (int unsigned k = 0; k < 4; k++) begin
      r = r[3] ? ({r[2:0], 1'b0} ^ 4'b1101) : {r[2:0], 1'b0};
    end
    return r ^ nib;
  endfunction

  always_comb begin
    crc = crc_step(crc_step(crc_step(crc_step(4'b0101, ser_id), ser_data[7:4]),
                            ser_data[3:0]), 4'h0);
  end

  always_comb begin
    transfer    = (state == OFFER) && frame_ack;
    decision    = enable && ((state == IDLE) || transfer);
    // OFFER is entered from LOAD or directly via the empty-FIFO re-offer.
    enter_offer = (state == LOAD) || (decision && fifo_empty);
  end

  always_comb begin
    ser_idx_nxt = ser_idx;
    if (transfer) begin
      ser_idx_nxt = enable ? ser_idx + 4'd1 : 4'd0;
    end
  end

  // State register
  always_ff @(posedge PCLK) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (decision) state_nxt = fifo_empty ? OFFER : FETCH;
      FETCH:   state_nxt = LOAD;
      LOAD:    state_nxt = OFFER;
      OFFER: begin
        if (transfer) begin
          if (decision) state_nxt = fifo_empty ? OFFER : FETCH;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    fifo_rd_en   = (state == FETCH);
    frame_req    = (state == OFFER);
    busy         = (state != IDLE);
    frame_status = '0;
    if (state == OFFER) begin
      frame_status = {(ser_idx == 4'd0), msg[4'd15 - ser_idx], 2'b00};
    end
  end

  // Datapath: word holding, serial sequencing, flags
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      frame_data <= '0;
      underrun   <= 1'b0;
      ser_idx    <= '0;
      msg        <= '0;
      msg_done   <= 1'b0;
    end else begin
      if (state == LOAD) frame_data <= fifo_rdata;
      if (decision && fifo_empty) underrun <= 1'b1;
      else if (underrun_clr)      underrun <= 1'b0;
      ser_idx <= ser_idx_nxt;
      // Snapshot the message only when its first frame is about to be offered.
      if (enter_offer && (ser_idx_nxt == 4'd0)) msg <= {ser_id, ser_data, crc};
      msg_done <= transfer && (ser_idx == 4'd15);
    end
  end

endmodule
